// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, frame-size limits and line idle level.
package uart_pkg;

   localparam int unsigned UART_MIN_BITS = 5;
   localparam logic        UART_IDLE     = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_t;

   // Out-of-range frame sizes fall back to the widest supported frame.
   function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int unsigned max_bits);
      int unsigned w;
      w = 32'(n);
      if (w < UART_MIN_BITS || w > max_bits) return 4'(max_bits);
      return n;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and occupancy count.
module sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 9
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_rdata;
   logic             w_wr;
   logic             w_rd;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_empty = (r_wptr == r_rptr);
   assign o_level = r_wptr - r_rptr;
   assign o_rdata = r_rdata;
   assign w_wr    = i_push & ~o_full;
   assign w_rd    = i_pop & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_rdata <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_rd) begin
            r_rptr  <= r_rptr + (AW+1)'(1);
            r_rdata <= r_mem[r_rptr[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO and per-frame data width, parity and stop-bit
// selection, timed from an oversampled baud clock shared with the receiver.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned MAX_BITS   = 9,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned OVS        = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_baud8_clk,
   input  logic                          i_wr,
   input  logic [MAX_BITS-1:0]           i_data,
   input  logic [3:0]                    i_nbits,
   input  logic                          i_par_en,
   input  logic                          i_par_odd,
   input  logic                          i_stop2,
   output logic                          o_tx,
   output logic                          o_txe,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_busy,
   output logic                          o_txc,
   output logic                          o_ovf
);

   localparam int unsigned TW = $clog2(OVS);

   logic [2:0]          r_bsync;
   logic                w_tick;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [MAX_BITS-1:0] w_rdata;
   tx_state_t           r_state;
   tx_state_t           w_state_nx;
   logic [TW-1:0]       r_tcnt;
   logic                r_align;
   logic                w_bit_end;
   logic [3:0]          r_bcnt;
   logic [3:0]          r_nbits;
   logic                r_par_en;
   logic                r_par_odd;
   logic                r_stop2;
   logic                r_load;
   logic [MAX_BITS-1:0] r_shift;
   logic [MAX_BITS-1:0] w_mask;
   logic                r_par;
   logic                r_tx;
   logic                w_tx_nx;
   logic                r_txc;
   logic                w_txc_nx;
   logic                r_ovf;

   assign w_tick = r_bsync[1] & ~r_bsync[2];
   assign w_push = i_wr & ~w_full;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (MAX_BITS)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_wdata (i_data),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

   // First tick after a latch from idle only aligns phase; bit timing starts there.
   assign w_bit_end = w_tick & ~r_align & (r_tcnt == TW'(OVS - 1));

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < MAX_BITS; i++) w_mask[i] = (i < 32'(r_nbits));
   end

   always_comb begin
      w_state_nx = r_state;
      w_pop      = 1'b0;
      w_txc_nx   = 1'b0;
      w_tx_nx    = UART_IDLE;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            w_tx_nx = 1'b0;
            if (w_bit_end) w_state_nx = S_DATA;
         end
         S_DATA: begin
            w_tx_nx = r_shift[0];
            if (w_bit_end && r_bcnt == r_nbits - 4'd1)
               w_state_nx = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            w_tx_nx = r_par;
            if (w_bit_end) w_state_nx = S_STOP;
         end
         S_STOP: begin
            if (w_bit_end && r_bcnt == {3'b000, r_stop2}) begin
               if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_state_nx = S_START;
               end else begin
                  w_state_nx = S_IDLE;
                  w_txc_nx   = 1'b1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bsync   <= '0;
         r_state   <= S_IDLE;
         r_tcnt    <= '0;
         r_align   <= 1'b1;
         r_bcnt    <= '0;
         r_nbits   <= 4'(MAX_BITS);
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_stop2   <= 1'b0;
         r_load    <= 1'b0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_tx      <= UART_IDLE;
         r_txc     <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_bsync <= {r_bsync[1:0], i_baud8_clk};
         r_state <= w_state_nx;
         r_tx    <= w_tx_nx;
         r_txc   <= w_txc_nx;
         r_ovf   <= i_wr & w_full;
         r_load  <= w_pop;

         if (r_state == S_IDLE) begin
            r_tcnt  <= '0;
            r_align <= 1'b1;
         end else if (w_tick) begin
            if (r_align) r_align <= 1'b0;
            else         r_tcnt  <= r_tcnt + TW'(1);
         end

         if (r_state != w_state_nx) r_bcnt <= '0;
         else if (w_bit_end)        r_bcnt <= r_bcnt + 4'd1;

         if (w_pop) begin
            r_nbits   <= clamp_nbits(i_nbits, MAX_BITS);
            r_par_en  <= i_par_en;
            r_par_odd <= i_par_odd;
            r_stop2   <= i_stop2;
         end

         // Read data lands one cycle after the pop, still well inside the start bit.
         if (r_load) begin
            r_shift <= w_rdata;
            r_par   <= (^(w_rdata & w_mask)) ^ r_par_odd;
         end else if (r_state == S_DATA && w_bit_end) begin
            r_shift <= r_shift >> 1;
         end
      end
   end

   assign o_tx    = r_tx;
   assign o_txe   = ~w_full;
   assign o_empty = w_empty;
   assign o_busy  = (r_state != S_IDLE);
   assign o_txc   = r_txc;
   assign o_ovf   = r_ovf;

endmodule
